control_fsm: RTL and testbench
==============================

Name: control_fsm

Overview:
- Top-level sequencing and configuration controller for the 4-in/4-out FIFO switch (input FIFOs, mux/demux, round-robin arbiter, output FIFOs, request counter).
- Drives the almost-full/almost-empty thresholds alto/bajo to all eight FIFOs.
- Produces the IDLE qualifier consumed by the counter.
- Supervises FIFO error flags and latches them.
- Moore machine; all outputs are registered.

Parameters:
NUM_FIFOS, 8, number of supervised FIFOs (width of empty_fifos and fifo_error).
THR_WIDTH, 3, width of the threshold buses alto/bajo.
MAX_THR, 7, largest legal alto value (FIFO depth minus 1).
RST_ALTO, 6, alto value driven out of reset.
RST_BAJO, 1, bajo value driven out of reset.
IDLE_DLY, 4, consecutive all-empty cycles in ACTIVE before returning to IDLE (range 1..15).

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
init  input  1  request (re)configuration; level-sensitive
umbral_alto  input  THR_WIDTH  requested alto threshold, sampled only in INIT
umbral_bajo  input  THR_WIDTH  requested bajo threshold, sampled only in INIT
empty_fifos  input  NUM_FIFOS  empty flags; bits 0..3 input FIFOs, bits 4..7 output FIFOs
fifo_error  input  NUM_FIFOS  per-FIFO overflow/underflow pulse
alto  output  THR_WIDTH  active almost-full threshold
bajo  output  THR_WIDTH  active almost-empty threshold
state  output  5  one-hot state: [0]RESET [1]INIT [2]IDLE [3]ACTIVE [4]ERROR
IDLE  output  1  high only in IDLE
active  output  1  high only in ACTIVE; arbiter enable
cfg_err  output  1  high while in INIT with an illegal threshold request
error_full  output  NUM_FIFOS  sticky OR of fifo_error, captured while in ERROR

Behaviour:

Reset (async, any time, including mid-transfer):
- state=00001 (RESET), alto=RST_ALTO, bajo=RST_BAJO.
- IDLE=0, active=0, cfg_err=0, error_full=0, idle_cnt=0.

State transitions. Priority per cycle is: ERROR > init > normal transition.
- RESET: next edge after reset deasserts, go to INIT unconditionally.
- INIT: every cycle, evaluate legal = (umbral_bajo < umbral_alto) && (umbral_alto <= MAX_THR).
  - If legal: alto/bajo load umbral_alto/umbral_bajo on that edge and cfg_err=0.
  - If illegal: alto/bajo hold their previous values and cfg_err=1.
  - Leave to IDLE when init=0 and legal. Otherwise stay in INIT, so an illegal request holds the block in INIT.
- IDLE:
  - any |fifo_error goes to ERROR;
  - else init=1 goes to INIT;
  - else any empty_fifos bit = 0 goes to ACTIVE (entered the cycle after the flag drops);
  - else stay in IDLE.
- ACTIVE:
  - |fifo_error goes to ERROR;
  - else init=1 goes to INIT;
  - else idle_cnt counts consecutive cycles with empty_fifos all ones, and resets to 0 on any non-empty cycle;
  - when idle_cnt reaches IDLE_DLY-1 and the current cycle is all-empty, go to IDLE (exactly IDLE_DLY all-empty cycles).
  - idle_cnt saturates and never wraps.
- ERROR:
  - error_full |= fifo_error every cycle; the triggering pulse is captured on the transition edge.
  - Absorbing state: init is ignored; only reset exits.
- fifo_error is ignored in RESET and INIT.

Outputs:
- Decoded from the registered state, so flags change one cycle after the deciding input edge.
- alto/bajo change only in INIT.
- In ERROR, active=0, which freezes arbiter pops/pushes.
- idle_cnt clears on every state entry.

Simultaneous events:
- fifo_error and init in the same cycle: go to ERROR.
- init asserted with non-empty FIFOs in IDLE: go to INIT.
- reset overrides everything.

Test Plan:
- Reset, then release with init=1, umbral_alto=5, umbral_bajo=2 → state RESET→INIT; alto=5, bajo=2 after the first INIT edge; init=0 → IDLE=1 the next cycle.
- In INIT, set umbral_alto=2, umbral_bajo=3 → cfg_err=1, alto/bajo keep 5/2, state stays INIT; correct to bajo=1 and init=0 → cfg_err=0, alto=2, bajo=1, IDLE.
- From IDLE, drive empty_fifos=8'hFE for 1 cycle, then 8'hFF; IDLE_DLY=4 → active=1 the cycle after; IDLE returns exactly 4 all-empty cycles later; a non-empty glitch at all-empty cycle 3 restarts the count.
- In ACTIVE, pulse fifo_error=8'h20, then 8'h01 two cycles later → state=10000, active=0, error_full=8'h21; init=1 has no effect; only reset clears it.
- Same-cycle init=1 and fifo_error=8'h04 in IDLE → ERROR, error_full=8'h04.
- Assert reset mid-ACTIVE (asynchronously, between edges) → outputs return to reset values immediately (alto=6, bajo=1, error_full=0); the sequence restarts via INIT.

Source files
------------

// File: rtl/control_fsm.sv
// Sequencing and configuration controller for the 4-in/4-out FIFO switch.
// Owns the alto/bajo thresholds, the IDLE qualifier and the sticky FIFO error capture.
//
// state  | meaning
// RESET  | just out of reset, thresholds at defaults
// INIT   | sampling umbral_alto/umbral_bajo, held here while the request is illegal
// IDLE   | all FIFOs empty, counter qualifier high
// ACTIVE | traffic present, arbiter enabled
// ERROR  | FIFO overflow/underflow seen, absorbing until reset
module control_fsm #(
   parameter int NUM_FIFOS = 8,
   parameter int THR_WIDTH = 3,
   parameter int MAX_THR   = 7,
   parameter int RST_ALTO  = 6,
   parameter int RST_BAJO  = 1,
   parameter int IDLE_DLY  = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 init,
   input  logic [THR_WIDTH-1:0] umbral_alto,
   input  logic [THR_WIDTH-1:0] umbral_bajo,
   input  logic [NUM_FIFOS-1:0] empty_fifos,
   input  logic [NUM_FIFOS-1:0] fifo_error,
   output logic [THR_WIDTH-1:0] alto,
   output logic [THR_WIDTH-1:0] bajo,
   output logic [4:0]           state,
   output logic                 IDLE,
   output logic                 active,
   output logic                 cfg_err,
   output logic [NUM_FIFOS-1:0] error_full
);

   typedef enum logic [4:0] {
      S_RESET  = 5'b00001,
      S_INIT   = 5'b00010,
      S_IDLE   = 5'b00100,
      S_ACTIVE = 5'b01000,
      S_ERROR  = 5'b10000
   } state_t;

   localparam logic [3:0]         CNT_LAST = 4'(IDLE_DLY - 1);
   localparam logic [THR_WIDTH:0] MAX_THR_W = (THR_WIDTH+1)'(MAX_THR);

   state_t                 state_q, state_d;
   logic [3:0]             idle_cnt_q, idle_cnt_d;
   logic [THR_WIDTH-1:0]   alto_q, bajo_q;
   logic                   idle_q, active_q, cfg_err_q;
   logic [NUM_FIFOS-1:0]   error_full_q;
   logic                   legal, all_empty, any_err;

   assign legal     = (umbral_bajo < umbral_alto) && ({1'b0, umbral_alto} <= MAX_THR_W);
   assign all_empty = &empty_fifos;
   assign any_err   = |fifo_error;

   always_comb begin
      state_d    = state_q;
      idle_cnt_d = idle_cnt_q;
      case (state_q)
         S_RESET: state_d = S_INIT;
         S_INIT: begin
            if (!init && legal) state_d = S_IDLE;
         end
         S_IDLE: begin
            if (any_err)         state_d = S_ERROR;
            else if (init)       state_d = S_INIT;
            else if (!all_empty) state_d = S_ACTIVE;
         end
         S_ACTIVE: begin
            if (any_err)                     state_d = S_ERROR;
            else if (init)                   state_d = S_INIT;
            else if (!all_empty)             idle_cnt_d = 4'd0;
            else if (idle_cnt_q == CNT_LAST) state_d = S_IDLE;
            else if (idle_cnt_q != 4'hF)     idle_cnt_d = idle_cnt_q + 4'd1;
         end
         S_ERROR: state_d = S_ERROR;
         default: state_d = S_RESET;
      endcase
      // Every state entry starts the all-empty run from zero.
      if (state_d != state_q) idle_cnt_d = 4'd0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= S_RESET;
         idle_cnt_q   <= 4'd0;
         alto_q       <= THR_WIDTH'(RST_ALTO);
         bajo_q       <= THR_WIDTH'(RST_BAJO);
         idle_q       <= 1'b0;
         active_q     <= 1'b0;
         cfg_err_q    <= 1'b0;
         error_full_q <= '0;
      end else begin
         state_q    <= state_d;
         idle_cnt_q <= idle_cnt_d;
         idle_q     <= (state_d == S_IDLE);
         active_q   <= (state_d == S_ACTIVE);
         cfg_err_q  <= (state_q == S_INIT) && !legal;
         if ((state_q == S_INIT) && legal) begin
            alto_q <= umbral_alto;
            bajo_q <= umbral_bajo;
         end
         // Includes the edge that enters ERROR, so the triggering pulse is kept.
         if (state_d == S_ERROR) error_full_q <= error_full_q | fifo_error;
      end
   end

   assign state      = state_q;
   assign alto       = alto_q;
   assign bajo       = bajo_q;
   assign IDLE       = idle_q;
   assign active     = active_q;
   assign cfg_err    = cfg_err_q;
   assign error_full = error_full_q;

endmodule

// File: tb/tb_control_fsm.sv
// Directed bench for control_fsm: stimulus pushes hand-computed expectations,
// a monitor pops and compares them after each clock edge or on an asynchronous event.
module tb_control_fsm;

   localparam logic [4:0] RST = 5'b00001, INI = 5'b00010, IDL = 5'b00100,
                          ACT = 5'b01000, ERR = 5'b10000;

   typedef struct {
      string      label;
      logic [4:0] st;
      logic [2:0] a;
      logic [2:0] b;
      logic       cfg;
      logic [7:0] ef;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset, init;
   logic [2:0] umbral_alto, umbral_bajo;
   logic [7:0] empty_fifos, fifo_error;
   logic [2:0] alto, bajo;
   logic [4:0] state;
   logic       IDLE, active, cfg_err;
   logic [7:0] error_full;

   exp_t q[$];
   int   checks = 0;
   int   passed = 0;
   event chk_ev;

   control_fsm dut (
      .clk(clk), .reset(reset), .init(init),
      .umbral_alto(umbral_alto), .umbral_bajo(umbral_bajo),
      .empty_fifos(empty_fifos), .fifo_error(fifo_error),
      .alto(alto), .bajo(bajo), .state(state), .IDLE(IDLE),
      .active(active), .cfg_err(cfg_err), .error_full(error_full)
   );

   always #5 clk = ~clk;

   // Monitor: compares every queued expectation shortly after an edge or async event.
   initial begin
      forever begin
         @(posedge clk or chk_ev);
         #1;
         while (q.size() != 0) begin
            exp_t e;
            logic [22:0] act_v, exp_v;
            e = q.pop_front();
            act_v = {state, alto, bajo, IDLE, active, cfg_err, error_full};
            exp_v = {e.st, e.a, e.b, (e.st == IDL), (e.st == ACT), e.cfg, e.ef};
            checks++;
            if (act_v === exp_v) passed++;
            else $display("FAIL %s: got state=%b alto=%0d bajo=%0d IDLE=%b active=%b cfg_err=%b error_full=%h, want state=%b alto=%0d bajo=%0d IDLE=%b active=%b cfg_err=%b error_full=%h",
                          e.label, state, alto, bajo, IDLE, active, cfg_err, error_full,
                          e.st, e.a, e.b, (e.st == IDL), (e.st == ACT), e.cfg, e.ef);
         end
      end
   end

   task automatic push(input string lbl, input logic [4:0] st, input logic [2:0] a,
                       input logic [2:0] b, input logic cfg, input logic [7:0] ef);
      exp_t e;
      e.label = lbl; e.st = st; e.a = a; e.b = b; e.cfg = cfg; e.ef = ef;
      q.push_back(e);
   endtask

   // One clock: drive inputs at the falling edge, expect the given outputs after the next rising edge.
   task automatic step(input string lbl, input logic i_init, input logic [2:0] ua,
                       input logic [2:0] ub, input logic [7:0] emp, input logic [7:0] err,
                       input logic [4:0] st, input logic [2:0] a, input logic [2:0] b,
                       input logic cfg, input logic [7:0] ef);
      @(negedge clk);
      reset = 1'b0; init = i_init; umbral_alto = ua; umbral_bajo = ub;
      empty_fifos = emp; fifo_error = err;
      push(lbl, st, a, b, cfg, ef);
      @(posedge clk);
   endtask

   task automatic async_reset(input string lbl);
      @(posedge clk);
      #2;
      reset = 1'b1;
      push(lbl, RST, 3'd6, 3'd1, 1'b0, 8'h00);
      ->chk_ev;
      #2;
   endtask

   initial begin
      reset = 1'b1; init = 1'b0; umbral_alto = 3'd0; umbral_bajo = 3'd0;
      empty_fifos = 8'hFF; fifo_error = 8'h00;
      @(negedge clk);
      push("reset_values", RST, 3'd6, 3'd1, 1'b0, 8'h00);
      ->chk_ev;
      #2;

      // Bring-up with a legal request.
      step("rst_to_init",   1, 3'd5, 3'd2, 8'hFF, 8'h00, INI, 3'd6, 3'd1, 0, 8'h00);
      step("init_load",     1, 3'd5, 3'd2, 8'hFF, 8'h00, INI, 3'd5, 3'd2, 0, 8'h00);
      step("init_to_idle",  0, 3'd5, 3'd2, 8'hFF, 8'h00, IDL, 3'd5, 3'd2, 0, 8'h00);
      step("idle_hold",     0, 3'd5, 3'd2, 8'hFF, 8'h00, IDL, 3'd5, 3'd2, 0, 8'h00);

      // Illegal requests hold INIT and keep thresholds; ua==ub is illegal too.
      step("idle_to_init",  1, 3'd2, 3'd3, 8'hFF, 8'h00, INI, 3'd5, 3'd2, 0, 8'h00);
      step("cfg_err_set",   1, 3'd2, 3'd3, 8'hFF, 8'h00, INI, 3'd5, 3'd2, 1, 8'h00);
      step("illegal_hold",  0, 3'd2, 3'd3, 8'hFF, 8'h00, INI, 3'd5, 3'd2, 1, 8'h00);
      step("equal_illegal", 1, 3'd4, 3'd4, 8'hFF, 8'hFF, INI, 3'd5, 3'd2, 1, 8'h00);
      step("cfg_fix_idle",  0, 3'd2, 3'd1, 8'hFF, 8'h00, IDL, 3'd2, 3'd1, 0, 8'h00);

      // Exactly IDLE_DLY all-empty cycles return to IDLE.
      step("to_active",     0, 3'd0, 3'd0, 8'hFE, 8'h00, ACT, 3'd2, 3'd1, 0, 8'h00);
      for (int i = 1; i <= 3; i++)
         step($sformatf("empty_run_%0d", i), 0, 3'd0, 3'd0, 8'hFF, 8'h00, ACT, 3'd2, 3'd1, 0, 8'h00);
      step("empty_run_4",   0, 3'd0, 3'd0, 8'hFF, 8'h00, IDL, 3'd2, 3'd1, 0, 8'h00);

      // A non-empty glitch on all-empty cycle 3 restarts the run.
      step("to_active_2",   0, 3'd0, 3'd0, 8'h7F, 8'h00, ACT, 3'd2, 3'd1, 0, 8'h00);
      step("run_a1",        0, 3'd0, 3'd0, 8'hFF, 8'h00, ACT, 3'd2, 3'd1, 0, 8'h00);
      step("run_a2",        0, 3'd0, 3'd0, 8'hFF, 8'h00, ACT, 3'd2, 3'd1, 0, 8'h00);
      step("glitch",        0, 3'd0, 3'd0, 8'hFE, 8'h00, ACT, 3'd2, 3'd1, 0, 8'h00);
      for (int i = 1; i <= 3; i++)
         step($sformatf("run_b%0d", i), 0, 3'd0, 3'd0, 8'hFF, 8'h00, ACT, 3'd2, 3'd1, 0, 8'h00);
      step("run_b4_idle",   0, 3'd0, 3'd0, 8'hFF, 8'h00, IDL, 3'd2, 3'd1, 0, 8'h00);

      // init wins over non-empty FIFOs in IDLE, and init in ACTIVE goes to INIT.
      step("idle_init_pri", 1, 3'd2, 3'd1, 8'hFE, 8'h00, INI, 3'd2, 3'd1, 0, 8'h00);
      step("reidle",        0, 3'd2, 3'd1, 8'hFF, 8'h00, IDL, 3'd2, 3'd1, 0, 8'h00);
      step("to_active_3",   0, 3'd0, 3'd0, 8'hEF, 8'h00, ACT, 3'd2, 3'd1, 0, 8'h00);
      step("active_init",   1, 3'd2, 3'd1, 8'hEF, 8'h00, INI, 3'd2, 3'd1, 0, 8'h00);
      step("reidle_2",      0, 3'd2, 3'd1, 8'hFF, 8'h00, IDL, 3'd2, 3'd1, 0, 8'h00);

      // Errors in ACTIVE accumulate and ERROR ignores init.
      step("to_active_4",   0, 3'd0, 3'd0, 8'hFE, 8'h00, ACT, 3'd2, 3'd1, 0, 8'h00);
      step("err_20",        0, 3'd0, 3'd0, 8'hFE, 8'h20, ERR, 3'd2, 3'd1, 0, 8'h20);
      step("err_quiet",     0, 3'd0, 3'd0, 8'hFE, 8'h00, ERR, 3'd2, 3'd1, 0, 8'h20);
      step("err_01",        0, 3'd0, 3'd0, 8'hFE, 8'h01, ERR, 3'd2, 3'd1, 0, 8'h21);
      step("err_init_ign",  1, 3'd5, 3'd2, 8'hFF, 8'h00, ERR, 3'd2, 3'd1, 0, 8'h21);
      step("err_absorb",    0, 3'd5, 3'd2, 8'hFF, 8'h00, ERR, 3'd2, 3'd1, 0, 8'h21);

      async_reset("reset_from_error");
      step("restart_init",  1, 3'd5, 3'd2, 8'hFF, 8'hFF, INI, 3'd6, 3'd1, 0, 8'h00);
      step("init_err_ign",  1, 3'd5, 3'd2, 8'hFF, 8'h80, INI, 3'd5, 3'd2, 0, 8'h00);
      step("restart_idle",  0, 3'd5, 3'd2, 8'hFF, 8'h00, IDL, 3'd5, 3'd2, 0, 8'h00);
      step("to_active_5",   0, 3'd0, 3'd0, 8'hFD, 8'h00, ACT, 3'd5, 3'd2, 0, 8'h00);
      step("active_busy",   0, 3'd0, 3'd0, 8'hFD, 8'h00, ACT, 3'd5, 3'd2, 0, 8'h00);

      async_reset("reset_mid_active");
      step("restart_init2", 1, 3'd4, 3'd3, 8'hFF, 8'h00, INI, 3'd6, 3'd1, 0, 8'h00);
      step("restart_idle2", 0, 3'd4, 3'd3, 8'hFF, 8'h00, IDL, 3'd4, 3'd3, 0, 8'h00);

      // Same-cycle init and error in IDLE: error wins.
      step("init_and_err",  1, 3'd5, 3'd2, 8'hFF, 8'h04, ERR, 3'd4, 3'd3, 0, 8'h04);
      step("err_hold_04",   0, 3'd5, 3'd2, 8'hFF, 8'h00, ERR, 3'd4, 3'd3, 0, 8'h04);

      @(posedge clk);
      #3;
      if (q.size() != 0) begin
         checks++;
         $display("FAIL pending_expectations: got %0d unchecked, want 0", q.size());
      end
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
